// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// port and a DMA/loader port. One grant per cycle, read data returned one cycle
// after the grant to the requester that issued the read.
// Optional build macro DMEM_ARB_RR_EN: round-robin arbitration between the two
// requesters instead of core priority with DMA starvation forcing.
module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wd,
   output logic              c_gnt,
   output logic              c_stall,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rd,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wd,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rd,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wd,
   input  logic [DATA_W-1:0] m_rd
);

   logic d_win;
   logic rpend;
   logic rsel;

`ifdef DMEM_ARB_RR_EN
   // last = 1 when the DMA held the most recent grant
   logic last;

   // Round-robin: on contention the requester not granted most recently wins
   always_comb begin
      d_win = d_req & (~c_req | ~last);
   end

   // Remember who was granted last; idle cycles leave it unchanged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= 1'b0;
      end else if (c_gnt | d_gnt) begin
         last <= d_gnt;
      end
   end
`else
   localparam logic [3:0] WMAX = 4'(MAX_WAIT);

   logic [3:0] wcnt;
   logic       forced;

   // Core priority, except when the DMA has been denied MAX_WAIT cycles in a row
   always_comb begin
      forced = d_req & (wcnt == WMAX);
      d_win  = d_req & (~c_req | forced);
   end

   // Count consecutive denied DMA cycles, saturating at MAX_WAIT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt <= '0;
      end else if (~d_req | d_gnt) begin
         wcnt <= '0;
      end else if (wcnt != WMAX) begin
         wcnt <= wcnt + 4'd1;
      end
   end
`endif

   // Grants are gated by reset so nothing reaches memory while reset is low
   always_comb begin
      d_gnt   = reset & d_win;
      c_gnt   = reset & c_req & ~d_win;
      c_stall = c_req & ~c_gnt;
   end

   // Route the granted bundle to memory; all zero when idle
   always_comb begin
      m_en   = c_gnt | d_gnt;
      m_we   = 1'b0;
      m_addr = '0;
      m_wd   = '0;
      if (c_gnt) begin
         m_we   = c_we;
         m_addr = c_addr;
         m_wd   = c_wd;
      end else if (d_gnt) begin
         m_we   = d_we;
         m_addr = d_addr;
         m_wd   = d_wd;
      end
   end

   // Track an outstanding read and which requester owns the returning data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpend <= 1'b0;
         rsel  <= 1'b0;
      end else begin
         rpend <= m_en & ~m_we;
         rsel  <= d_gnt;
      end
   end

   // Read data is steered to its owner and held at zero otherwise
   always_comb begin
      c_rvalid = rpend & ~rsel;
      d_rvalid = rpend & rsel;
      c_rd     = c_rvalid ? m_rd : '0;
      d_rd     = d_rvalid ? m_rd : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// behavioural arbitration/memory model. Honours DMEM_ARB_RR_EN when defined.
module tb_dmem_arbiter;

   localparam int unsigned MW = 4;

   logic        clk;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wd, d_addr, d_wd;
   logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
   logic [31:0] c_rd, d_rd;
   logic        m_en, m_we;
   logic [31:0] m_addr, m_wd, m_rd;

   int total;
   int bad;

   // memory seen by the DUT: one-cycle read latency
   logic [31:0] mem [0:255];

   // reference model state
   int          waited;
   bit          last_d;
   bit          pend_c, pend_d;
   logic [31:0] pend_data;
   logic [31:0] ref_mem [0:255];

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rd(c_rd),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rd(d_rd),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr[9:2]] <= m_wd;
         else      m_rd <= mem[m_addr[9:2]];
      end
   end

   task automatic idle_inputs();
      c_req = 0; c_we = 0; c_addr = 0; c_wd = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
   endtask

   task automatic model_reset();
      waited = 0; last_d = 0; pend_c = 0; pend_d = 0; pend_data = 0;
   endtask

   // who should win given the current request inputs
   task automatic model_grant(output bit gc, output bit gd);
`ifdef DMEM_ARB_RR_EN
      gd = d_req && (!c_req || !last_d);
`else
      gd = d_req && (!c_req || waited == MW);
`endif
      gc = c_req && !gd;
   endtask

   // effects of the clock edge on the model
   task automatic model_clock(input bit gc, input bit gd);
      if (!d_req || gd) waited = 0;
      else if (waited < MW) waited = waited + 1;
      if (gc || gd) last_d = gd;
      pend_c = gc && !c_we;
      pend_d = gd && !d_we;
      if (gc) begin
         if (c_we) ref_mem[c_addr[9:2]] = c_wd; else pend_data = ref_mem[c_addr[9:2]];
      end else if (gd) begin
         if (d_we) ref_mem[d_addr[9:2]] = d_wd; else pend_data = ref_mem[d_addr[9:2]];
      end
   endtask

   task automatic advance();
      bit gc, gd;
      model_grant(gc, gd);
      model_clock(gc, gd);
      @(negedge clk);
   endtask

   task automatic dma_write(input logic [31:0] a, input logic [31:0] v);
      idle_inputs();
      d_req = 1; d_we = 1; d_addr = a; d_wd = v;
      #1;
      advance();
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 0;
      idle_inputs();
      c_req = 1; d_req = 1; c_addr = 32'h10; d_addr = 32'h14;
      #1;
      total++; if (c_gnt !== 1'b0) begin bad++; $display("FAIL rst_c_gnt got=%b want=0", c_gnt); end
      total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt got=%b want=0", d_gnt); end
      total++; if (m_en !== 1'b0) begin bad++; $display("FAIL rst_m_en got=%b want=0", m_en); end
      @(posedge clk); #1;
      total++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         bad++; $display("FAIL rst_rvalid got=%b%b want=00", c_rvalid, d_rvalid); end
      total++; if (c_rd !== 32'h0 || d_rd !== 32'h0) begin
         bad++; $display("FAIL rst_rd got=%h/%h want=0/0", c_rd, d_rd); end
      @(negedge clk);
      reset = 1;
      idle_inputs();
      model_reset();
      #1;
      advance();
   endtask

   task automatic test_core_read();
      dma_write(32'h10, 32'hDEADBEEF);
      c_req = 1; c_we = 0; c_addr = 32'h10;
      #1;
      total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL cr_gnt got=%b want=1", c_gnt); end
      total++; if (m_addr !== 32'h10 || m_we !== 1'b0) begin
         bad++; $display("FAIL cr_maddr got=%h we=%b want=10 we=0", m_addr, m_we); end
      advance();
      idle_inputs();
      #1;
      total++; if (c_rvalid !== 1'b1 || c_rd !== 32'hDEADBEEF) begin
         bad++; $display("FAIL cr_data got=%b/%h want=1/deadbeef", c_rvalid, c_rd); end
      total++; if (d_rvalid !== 1'b0 || d_rd !== 32'h0) begin
         bad++; $display("FAIL cr_dvalid got=%b/%h want=0/0", d_rvalid, d_rd); end
      advance();
   endtask

   // both requesters held: expected grant pattern from closed form, not the model
   task automatic contend(input string tag, input int n);
      bit exp_d;
      for (int i = 0; i < n; i++) begin
         c_req = 1; c_we = 1; c_addr = 32'h100; c_wd = i;
         d_req = 1; d_we = 1; d_addr = 32'h104; d_wd = i;
         #1;
`ifdef DMEM_ARB_RR_EN
         exp_d = (i % 2) == 0;
`else
         exp_d = (i % (MW + 1)) == MW;
`endif
         total++; if (d_gnt !== exp_d || c_gnt !== !exp_d || c_stall !== exp_d) begin
            bad++; $display("FAIL %s cyc%0d got d=%b c=%b st=%b want d=%b", tag, i, d_gnt, c_gnt, c_stall, exp_d); end
         advance();
      end
      idle_inputs();
   endtask

   task automatic test_contention();
      @(negedge clk);
      reset = 0; #2; reset = 1;
      model_reset();
      idle_inputs();
      #1;
      advance();
      contend("contend", 10);
      #1;
      advance();
   endtask

   task automatic test_interleaved();
      dma_write(32'h20, 32'h11111111);
      dma_write(32'h24, 32'h22222222);
      c_req = 1; c_we = 0; c_addr = 32'h20;
      #1;
      total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL il_cgnt got=%b want=1", c_gnt); end
      advance();
      idle_inputs();
      d_req = 1; d_we = 0; d_addr = 32'h24;
      #1;
      total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL il_dgnt got=%b want=1", d_gnt); end
      total++; if (c_rvalid !== 1'b1 || c_rd !== 32'h11111111) begin
         bad++; $display("FAIL il_c got=%b/%h want=1/11111111", c_rvalid, c_rd); end
      advance();
      idle_inputs();
      #1;
      total++; if (d_rvalid !== 1'b1 || d_rd !== 32'h22222222 || c_rvalid !== 1'b0) begin
         bad++; $display("FAIL il_d got=%b/%h c=%b want=1/22222222 c=0", d_rvalid, d_rd, c_rvalid); end
      advance();
   endtask

   task automatic test_dma_write();
      idle_inputs();
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wd = 32'hA5A5A5A5;
      #1;
      total++; if (d_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b1 || m_wd !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL dw_bus got gnt=%b en=%b we=%b wd=%h want 1 1 1 a5a5a5a5", d_gnt, m_en, m_we, m_wd); end
      advance();
      idle_inputs();
      #1;
      total++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         bad++; $display("FAIL dw_norv got=%b%b want=00", c_rvalid, d_rvalid); end
      advance();
      c_req = 1; c_we = 0; c_addr = 32'h40;
      #1;
      advance();
      idle_inputs();
      #1;
      total++; if (c_rvalid !== 1'b1 || c_rd !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL dw_readback got=%b/%h want=1/a5a5a5a5", c_rvalid, c_rd); end
      advance();
   endtask

   task automatic test_reset_mid_read();
      idle_inputs();
      c_req = 1; c_we = 0; c_addr = 32'h10;
      #1;
      total++; if (c_gnt !== 1'b1) begin bad++; $display("FAIL rm_gnt got=%b want=1", c_gnt); end
      #1;
      reset = 0;
      d_req = 1; d_addr = 32'h14;
      #1;
      total++; if (c_gnt !== 1'b0 || d_gnt !== 1'b0 || m_en !== 1'b0) begin
         bad++; $display("FAIL rm_nogrant got c=%b d=%b en=%b want 0 0 0", c_gnt, d_gnt, m_en); end
      @(posedge clk); #1;
      total++; if (c_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid got=%b want=0", c_rvalid); end
      @(negedge clk);
      reset = 1;
      model_reset();
      idle_inputs();
      #1;
      total++; if (c_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         bad++; $display("FAIL rm_release got=%b%b want=00", c_rvalid, d_rvalid); end
      advance();
      // a cleared wait counter / last shows up as a fresh contention pattern
      contend("rm_contend", MW + 1);
      #1;
      advance();
   endtask

   task automatic test_random();
      bit gc, gd, pgc, pgd;
      logic [31:0] ea, ew;
      bit ewe;
      for (int w = 0; w < 16; w++) dma_write(w * 4, $urandom);
      pgc = 1; pgd = 1;
      for (int i = 0; i < 400; i++) begin
         if (!(c_req && !pgc)) begin
            c_req = ($urandom_range(0, 3) != 0); c_we = $urandom_range(0, 1);
            c_addr = $urandom_range(0, 15) * 4; c_wd = $urandom;
         end
         if (!(d_req && !pgd)) begin
            d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1);
            d_addr = $urandom_range(0, 15) * 4; d_wd = $urandom;
         end
         #1;
         model_grant(gc, gd);
         ea = gc ? c_addr : gd ? d_addr : 32'h0;
         ew = gc ? c_wd : gd ? d_wd : 32'h0;
         ewe = gc ? c_we : gd ? d_we : 1'b0;
         total++; if (c_gnt !== gc || d_gnt !== gd || c_stall !== (c_req && !gc)) begin
            bad++; $display("FAIL rnd_gnt cyc%0d got c=%b d=%b st=%b want c=%b d=%b", i, c_gnt, d_gnt, c_stall, gc, gd); end
         total++; if (m_en !== (gc || gd) || m_we !== ewe || m_addr !== ea || m_wd !== ew) begin
            bad++; $display("FAIL rnd_bus cyc%0d got en=%b we=%b a=%h wd=%h want we=%b a=%h wd=%h", i, m_en, m_we, m_addr, m_wd, ewe, ea, ew); end
         total++; if (c_rvalid !== pend_c || d_rvalid !== pend_d) begin
            bad++; $display("FAIL rnd_rv cyc%0d got=%b%b want=%b%b", i, c_rvalid, d_rvalid, pend_c, pend_d); end
         total++; if (c_rd !== (pend_c ? pend_data : 32'h0) || d_rd !== (pend_d ? pend_data : 32'h0)) begin
            bad++; $display("FAIL rnd_rd cyc%0d got=%h/%h want data=%h", i, c_rd, d_rd, pend_data); end
         pgc = gc; pgd = gd;
         model_clock(gc, gd);
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 0;
      idle_inputs();
      model_reset();
      for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;
      @(negedge clk);
      test_reset();
      test_core_read();
      test_contention();
      test_interleaved();
      test_dma_write();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the core's load/store port and a DMA/loader port. Sits between `RISC_V_single_cycle`'s data-memory connection (ALU result as address, RD2 as write data) and `data_Memory`. It grants one requester per cycle and routes the one-cycle-latency read data back to the requester that issued the read. It drives a stall to the core when the core loses arbitration, and bounds DMA starvation with a wait counter.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: consecutive denied DMA cycles before the DMA is forced ahead of the core. Legal range is 1..15.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `c_req` in 1: core memory access request (load or store).
- `c_we` in 1: core write enable.
- `c_addr` in ADDR_W: core address.
- `c_wd` in DATA_W: core write data.
- `c_gnt` out 1: core granted this cycle (combinational).
- `c_stall` out 1: `c_req & ~c_gnt`. The core holds PC and suppresses register write.
- `c_rvalid` out 1: core read data valid (registered).
- `c_rd` out DATA_W: core read data.
- `d_req`, `d_we`, `d_addr`, `d_wd`: DMA request bundle, same meaning as the core bundle.
- `d_gnt`, `d_rvalid`, `d_rd` out: DMA grant, read valid and read data.
- `m_en` out 1: memory access this cycle.
- `m_we` out 1: memory write enable.
- `m_addr` out ADDR_W: memory address.
- `m_wd` out DATA_W: memory write data.
- `m_rd` in DATA_W: memory read data, valid the cycle after a read is issued.

## Operation
- **Grant.** Exactly one requester is granted per cycle, or none if neither requests. The grant is combinational from the request inputs, `wcnt`, and `last` (used only in RR mode).
- **Default priority** (applies when forced is false):
  - `c_req` set: core wins.
  - Else `d_req` set: DMA wins.
- **Forced rule.** `forced = d_req & (wcnt == MAX_WAIT)`. When `forced` is true the DMA wins regardless of `c_req`.
- **Wait counter `wcnt`** (4 bits, evaluated at the clock edge, first match wins):
  - `~d_req` or `d_gnt`: clear to 0.
  - Otherwise: increment, saturating at `MAX_WAIT`.
- **Memory mux.**
  - `m_en = c_gnt | d_gnt`.
  - `m_we`, `m_addr`, `m_wd` come from the granted bundle; they are zero when idle.
  - `m_we` is never asserted without `m_en`.
- **Read return.** The pipeline registers are `rpend`, set when the granted access is a read, and `rsel`, where 0 = core and 1 = DMA. In the cycle after a read grant, the selected `*_rvalid` is 1.
- **Read data routing.**
  - `c_rd` and `d_rd` equal `m_rd` when their own rvalid is set, otherwise 0.
  - The non-selected rvalid is 0.
- **Writes** produce no rvalid.
- **Back-to-back reads** from alternating requesters return in issue order, one per cycle.
- **Requester obligation.** A requester holds its bundle stable while `req=1` and `gnt=0`. `gnt` is the acceptance; there is no further handshake.

## Timing
- **Reset values** (asynchronous, `reset=0`):
  - Registers: `wcnt=0`, `rpend=0`, `rsel=0`, `last=0`.
  - Outputs: all `*_rvalid=0`, `*_rd=0`.
- **Outputs while in reset:** `m_en=0` and both grants = 0, regardless of requests.
- **Grant latency:** 0 cycles. **Read data latency:** 1 cycle after grant.
- **Reset mid-read:** asserting reset drops the pending rvalid. No data is returned after release.
- **Simultaneous requests:** with `c_req` and `d_req` held continuously, the DMA is granted once every `MAX_WAIT+1` cycles.
- **Release after forced grant:** the forced grant clears `wcnt`, so the core regains priority the next cycle.
- **`d_req` dropping while denied:** `wcnt` clears, with no grant issued.

## Configuration
- **`DMEM_ARB_RR_EN` defined:**
  - Round-robin: when both request, the requester not granted most recently (`last`) wins.
  - `last` updates on every grant.
  - `wcnt` logic and the `MAX_WAIT` forcing are compiled out.
- **`DMEM_ARB_RR_EN` undefined:** core-priority with starvation forcing, as described above.
- **Unchanged in both modes:** `c_stall`, the read-return path and reset behaviour.

## Test plan
- **Core-only read.** Stimulus: `c_req=1`, `c_we=0`, `c_addr=0x10`, memory holds `0xDEADBEEF`. Required: `c_gnt=1` and `m_addr=0x10` in cycle 0; `c_rvalid=1` and `c_rd=0xDEADBEEF` in cycle 1; `d_rvalid=0`.
- **Contention, default mode, `MAX_WAIT=4`.** Stimulus: `c_req` and `d_req` held for 10 cycles. Required: `d_gnt` exactly in cycles 4 and 9; `c_stall=1` in exactly those cycles.
- **Contention with `DMEM_ARB_RR_EN`.** Stimulus: both requests held 6 cycles, `last=0` after reset. Required: grants alternate DMA, core, DMA, core, DMA, core.
- **Interleaved reads.** Stimulus: core read at `0x20` (`0x11111111`) in cycle 0, DMA read at `0x24` (`0x22222222`) in cycle 1. Required: `c_rvalid` with `0x11111111` in cycle 1; `d_rvalid` with `0x22222222` in cycle 2.
- **DMA write.** Stimulus: `d_req=1`, `d_we=1`, `d_addr=0x40`, `d_wd=0xA5A5A5A5`. Required: `m_we=1`, `m_wd=0xA5A5A5A5` in the same cycle; no rvalid. A later core read of `0x40` returns `0xA5A5A5A5`.
- **Reset mid-read.** Stimulus: core read granted, then `reset=0` asserted before the next edge. Required: `c_rvalid` stays 0; `wcnt=0`; no grants while reset is low.
